// File: rtl/ffn_residual_wb_if.sv
// Memory write port of the FFN residual write-back stage.
// One beat transfers on every cycle with mem_wr_en && mem_wr_ready.
interface ffn_residual_wb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 136
);
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;

  modport master (output mem_wr_en, mem_wr_addr, mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_en, mem_wr_addr, mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/ffn_residual_wb.sv
// FFN residual write-back: captures 64-lane result tiles into a 2-entry buffer
// and serializes them as 8-lane beats onto a ready/valid memory write port.
module ffn_residual_wb #(
  parameter int BW_FP          = 17,
  parameter int VALUE_MN       = 64,
  parameter int LANES_PER_BEAT = 8,
  parameter int ADDR_W         = 10,
  parameter int TILE_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_wb,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [TILE_W-1:0]         num_tiles,
  input  logic [VALUE_MN*BW_FP-1:0] tile_in,
  input  logic                      tile_in_valid,
  ffn_residual_wb_if.master         mem,
  output logic                      busy_wb,
  output logic                      done_wb,
  output logic                      overflow_wb
);
  localparam int BEATS     = VALUE_MN / LANES_PER_BEAT;
  localparam int BEAT_W    = LANES_PER_BEAT * BW_FP;
  localparam int TILE_BITS = VALUE_MN * BW_FP;
  localparam int BI_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_n;

  logic [ADDR_W-1:0]    base_q;
  logic [TILE_W-1:0]    num_q, acc_q, acc_n, wr_tile_q, wr_tile_n;
  logic [BI_W-1:0]      beat_q, beat_n;
  logic [1:0]           cnt_q, cnt_n;
  logic                 hd_q, hd_n, tail;
  logic [TILE_BITS-1:0] buf_q [2];
  logic [TILE_BITS-1:0] head_src;

  logic                 en_q, en_n;
  logic [ADDR_W-1:0]    addr_q, addr_n;
  logic [BEAT_W-1:0]    data_q, data_n;
  logic                 busy_n, done_n, ovf_n;
  logic                 fire, last_fire, final_fire, want_push, push, pop, drop;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fire       = en_q && mem.mem_wr_ready;
    last_fire  = fire && (beat_q == BI_W'(BEATS - 1));
    final_fire = last_fire && (wr_tile_q == num_q - TILE_W'(1));
    pop        = last_fire;
    want_push  = (state_q == RUN) && tile_in_valid && (acc_q < num_q);
    // A full buffer still takes the tile when its head leaves this cycle.
    push       = want_push && ((cnt_q != 2'd2) || pop);
    drop       = want_push && !push;
    tail       = hd_q ^ cnt_q[0];
    cnt_n      = cnt_q + {1'b0, push} - {1'b0, pop};
    hd_n       = hd_q ^ pop;
    acc_n      = acc_q + TILE_W'(push);
    wr_tile_n  = wr_tile_q + TILE_W'(last_fire);
    beat_n     = fire ? (last_fire ? '0 : beat_q + BI_W'(1)) : beat_q;

    state_n = state_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: if (start_wb) state_n = (num_tiles == '0) ? FIN : RUN;
      RUN:  if (final_fire) begin
              state_n = FIN;
              done_n  = 1'b1;
            end
      // An empty job spends one extra FIN cycle so done lands two cycles after start.
      FIN:  begin
              done_n = !done_wb;
              if (done_wb) state_n = IDLE;
            end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN) || ((state_n == FIN) && !done_n);
    ovf_n  = ((state_q == IDLE) && start_wb) ? 1'b0 : (overflow_wb || drop);

    // Head after this cycle's push/pop; a tile landing straight at the head bypasses the buffer.
    head_src = (push && (tail == hd_n)) ? tile_in : buf_q[hd_n];

    en_n   = en_q;
    addr_n = addr_q;
    data_n = data_q;
    if (!(en_q && !mem.mem_wr_ready)) begin
      en_n = (state_n == RUN) && (cnt_n != 2'd0);
      if (en_n) begin
        addr_n = base_q + ADDR_W'(wr_tile_n) * ADDR_W'(BEATS) + ADDR_W'(beat_n);
        data_n = head_src[beat_n*BEAT_W +: BEAT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      acc_q       <= '0;
      wr_tile_q   <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      hd_q        <= 1'b0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_wb     <= 1'b0;
      done_wb     <= 1'b0;
      overflow_wb <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      wr_tile_q   <= wr_tile_n;
      beat_q      <= beat_n;
      cnt_q       <= cnt_n;
      hd_q        <= hd_n;
      en_q        <= en_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      busy_wb     <= busy_n;
      done_wb     <= done_n;
      overflow_wb <= ovf_n;
      if ((state_q == IDLE) && start_wb) begin
        base_q    <= base_addr;
        num_q     <= num_tiles;
        acc_q     <= '0;
        wr_tile_q <= '0;
        beat_q    <= '0;
      end
    end
  end

  // NOTE: tile storage is not reset; cnt_q/hd_q decide validity, so stale contents are never read out.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail] <= tile_in;
  end

  assign mem.mem_wr_en   = en_q;
  assign mem.mem_wr_addr = addr_q;
  assign mem.mem_wr_data = data_q;
endmodule

// File: doc/ffn_residual_wb.md
# ffn_residual_wb

Write-back stage directly downstream of the FFN residual-add controller. It captures each 64-lane FP result tile (single-cycle valid pulse, no backpressure available upstream) into a 2-entry tile buffer. It serializes each tile into 8-lane beats on a ready/valid memory write port and signals completion after a programmed number of tiles. Buffer overflow is flagged, never stalled.

## Interface
- BW_FP, 17, width of one FP lane
- VALUE_MN, 64, lanes per tile
- LANES_PER_BEAT, 8, lanes per memory write beat; VALUE_MN must be a multiple
- ADDR_W, 10, memory beat-address width
- TILE_W, 8, width of tile count

- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start_wb  input  1  pulse; latches base_addr and num_tiles, starts a job
- base_addr  input  ADDR_W  beat address of first beat of the job
- num_tiles  input  TILE_W  tiles to write in this job
- tile_in  input  VALUE_MN*BW_FP  result tile; lane i at bits [i*BW_FP +: BW_FP]
- tile_in_valid  input  1  one-cycle pulse qualifying tile_in
- mem_wr_en  output  1  write beat valid
- mem_wr_addr  output  ADDR_W  beat address
- mem_wr_data  output  LANES_PER_BEAT*BW_FP  beat data
- mem_wr_ready  input  1  memory accepts beat when mem_wr_en && mem_wr_ready
- busy_wb  output  1  job active
- done_wb  output  1  one-cycle pulse at job completion
- overflow_wb  output  1  sticky; tile arrived with buffer full

## Operation
- BEATS = VALUE_MN/LANES_PER_BEAT (8 by default).
- States:
  - IDLE: on start_wb, latch params, clear tile/beat counters and overflow_wb, go to RUN; if num_tiles==0 go to FIN instead.
  - RUN: accept tiles and emit beats. Go to FIN the cycle the last beat of tile num_tiles-1 is accepted.
  - FIN: done_wb=1 for one cycle, then IDLE.
- Tile accept in RUN: tile_in_valid with fewer than num_tiles tiles already accepted writes the tile to the buffer tail.
  - Buffer full (2 entries, none freeing this cycle): tile dropped, overflow_wb set, accept counter unchanged.
  - Tiles beyond num_tiles, or tile_in_valid in IDLE/FIN: ignored silently, no overflow.
- Emission: the head entry is sent as beats b=0..BEATS-1.
  - mem_wr_data = lanes [b*LANES_PER_BEAT, (b+1)*LANES_PER_BEAT) of the head, lowest lane in the LSBs.
  - mem_wr_addr = base_addr + tile_idx*BEATS + b, truncated mod 2^ADDR_W (wrap-around allowed).
  - tile_idx counts written tiles, not received ones.
- Acceptance of beat BEATS-1 pops the head entry.
- start_wb while busy_wb=1 is ignored; latched params are unchanged.
- Reset values: mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy_wb=0, done_wb=0, overflow_wb=0. Buffer empty, state IDLE.

## Timing
- All outputs are registered.
- busy_wb rises the cycle after start_wb and falls in the same cycle done_wb is high.
- Tile latency: tile_in_valid at cycle t into an empty buffer gives beat 0 with mem_wr_en=1 at t+1.
- With mem_wr_ready held high, beats occur on consecutive cycles t+1..t+BEATS.
- Handshake: while mem_wr_en=1 and mem_wr_ready=0, addr and data hold stable. mem_wr_en never drops without acceptance.
- Back-to-back tiles: the next buffered tile's beat 0 follows the previous tile's last accepted beat with no bubble.
- Simultaneous events:
  - Tile arrives with the buffer full in the same cycle the last head beat is accepted: tile is accepted, no overflow.
  - Simultaneous push into an empty buffer and pop: legal.
- done_wb is asserted the cycle after the final beat is accepted. With num_tiles==0 it is asserted 2 cycles after start_wb.
- rst_n low mid-job: at the next edge all state returns to reset values, pending beats are discarded, and done_wb does not pulse.

## Test plan
- num_tiles=1, base_addr=0x010, tile lanes = lane index, ready always high -> 8 beats, addr 0x010..0x017, beat b lanes 8b..8b+7, done_wb one cycle after beat 7.
- num_tiles=3, tiles every 8 cycles, mem_wr_ready toggling 1/0 -> 24 beats, addr contiguous, data stable during stalls, no overflow.
- num_tiles=4, 3 tiles on consecutive cycles, ready low for 20 cycles -> tiles 0,1 buffered, third tile dropped, overflow_wb=1. Only 2 tiles written, busy_wb stays high.
- base_addr=0x3FC, num_tiles=1 -> addresses 0x3FC..0x3FF, then 0x000..0x003.
- num_tiles=0 -> done_wb two cycles after start. A second start_wb during a busy job is ignored, and a tile_in_valid in IDLE produces no write.
- rst_n low during beat 3 of tile 0 -> next cycle mem_wr_en=0 and busy_wb=0. A new job after reset starts at beat 0 with overflow_wb=0.
